// File: rtl/vga_fetch_timing_if.sv
// Show-ahead pixel FIFO link: the FIFO side (master) presents the head word and
// its valid flag; the fetch engine (slave) returns a one-clock pop strobe.
interface vga_fetch_timing_if #(
    parameter int data_width = 8
);
    logic [data_width-1:0] fifo_data;
    logic                  fifo_valid;
    logic                  fifo_rd;

    modport master (
        output fifo_data,
        output fifo_valid,
        input  fifo_rd
    );

    modport slave (
        input  fifo_data,
        input  fifo_valid,
        output fifo_rd
    );
endinterface

// File: rtl/vga_fetch_timing.sv
// Programmable video timing generator with packed-pixel fetch from a show-ahead
// FIFO, optional pixel/line doubling and a sticky underflow flag.
module vga_fetch_timing #(
    parameter int h_visible  = 640,
    parameter int h_front    = 16,
    parameter int h_sync     = 96,
    parameter int h_back     = 48,
    parameter int v_visible  = 480,
    parameter int v_front    = 10,
    parameter int v_sync     = 2,
    parameter int v_back     = 33,
    parameter int hsync_pol  = 0,
    parameter int vsync_pol  = 0,
    parameter int bpp        = 1,
    parameter int data_width = 8,
    parameter int dbl_x      = 0,
    parameter int dbl_y      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    vga_fetch_timing_if.slave        fifo,
    input  logic                     underflow_clr,
    output logic [7:0]               pixel,
    output logic                     de,
    output logic                     hsync,
    output logic                     vsync,
    output logic [11:0]              x,
    output logic [11:0]              y,
    output logic                     frame_start,
    output logic                     underflow
);
    localparam int h_total    = h_visible + h_front + h_sync + h_back;
    localparam int v_total    = v_visible + v_front + v_sync + v_back;
    localparam int ppw        = data_width / bpp;
    localparam int lbuf_depth = h_visible / (ppw << dbl_x);
    localparam int idx_w      = (lbuf_depth > 1) ? $clog2(lbuf_depth) : 1;

    localparam logic [11:0] h_last   = 12'(h_total - 1);
    localparam logic [11:0] v_last   = 12'(v_total - 1);
    localparam logic [11:0] h_vis_w  = 12'(h_visible);
    localparam logic [11:0] v_vis_w  = 12'(v_visible);
    localparam logic [11:0] hs_start = 12'(h_visible + h_front);
    localparam logic [11:0] hs_end   = 12'(h_visible + h_front + h_sync);
    localparam logic [11:0] vs_start = 12'(v_visible + v_front);
    localparam logic [11:0] vs_end   = 12'(v_visible + v_front + v_sync);
    localparam logic [11:0] ppw_w    = 12'(ppw);
    localparam logic        hs_on    = (hsync_pol != 0);
    localparam logic        vs_on    = (vsync_pol != 0);
    localparam logic [data_width-1:0] pix_mask = data_width'((1 << bpp) - 1);

    // Pixels are packed LSB-first: slot 0 occupies the lowest bpp bits.
    function automatic logic [7:0] field(input logic [data_width-1:0] w,
                                         input logic [11:0]           s);
        field = 8'((w >> (s * bpp)) & pix_mask);
    endfunction

    logic [11:0]           h_p0, v_p0;
    logic [11:0]           p_p0, slot_p0;
    logic [idx_w-1:0]      j_p0;
    logic                  vis_p0, rep_p0, load_p0, fetch_p0;
    logic [data_width-1:0] src_p0, word_q;
    logic [7:0]            pix_p0;
    logic [data_width-1:0] lbuf [lbuf_depth];

    // Stage p0: decode the current counter position into fetch controls
    assign vis_p0   = (h_p0 < h_vis_w) && (v_p0 < v_vis_w);
    assign p_p0     = h_p0 >> dbl_x;
    assign slot_p0  = p_p0 % ppw_w;
    assign j_p0     = idx_w'(p_p0 / ppw_w);
    assign rep_p0   = (dbl_y != 0) && v_p0[0];
    assign load_p0  = vis_p0 && (slot_p0 == 12'd0) && ((dbl_x == 0) || !h_p0[0]);
    assign fetch_p0 = load_p0 && !rep_p0;

    assign fifo.fifo_rd = fetch_p0 && fifo.fifo_valid && !reset;

    always_comb begin
        src_p0 = word_q;
        if (load_p0) begin
            if (rep_p0)
                src_p0 = lbuf[j_p0];
            else if (fifo.fifo_valid)
                src_p0 = fifo.fifo_data;
            else
                src_p0 = '0;
        end
    end

    assign pix_p0 = vis_p0 ? field(src_p0, slot_p0) : 8'd0;

    always_ff @(posedge clk) begin
        if ((dbl_y != 0) && fetch_p0)
            lbuf[j_p0] <= src_p0;
    end

    // Stage p1: registered video outputs and raster counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_p0        <= '0;
            v_p0        <= '0;
            word_q      <= '0;
            de          <= 1'b0;
            pixel       <= 8'd0;
            hsync       <= ~hs_on;
            vsync       <= ~vs_on;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (h_p0 == h_last) begin
                h_p0 <= '0;
                v_p0 <= (v_p0 == v_last) ? 12'd0 : v_p0 + 12'd1;
            end else begin
                h_p0 <= h_p0 + 12'd1;
            end
            if (load_p0)
                word_q <= src_p0;
            de          <= vis_p0;
            pixel       <= pix_p0;
            hsync       <= ((h_p0 >= hs_start) && (h_p0 < hs_end)) ? hs_on : ~hs_on;
            vsync       <= ((v_p0 >= vs_start) && (v_p0 < vs_end)) ? vs_on : ~vs_on;
            x           <= h_p0;
            y           <= v_p0;
            frame_start <= (h_p0 == h_last) && (v_p0 == v_last);
            // A new underflow outranks a simultaneous clear.
            if (fetch_p0 && !fifo.fifo_valid)
                underflow <= 1'b1;
            else if (underflow_clr)
                underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_fetch_timing.sv
// Four timing-identical instances (bpp1, bpp4, bpp2+dbl_x, bpp8+dbl_y with
// positive syncs) checked against a per-clock expected-output queue.
module tb_vga_fetch_timing;
    localparam int BPP_C [4] = '{1, 4, 2, 8};
    localparam int DX_C  [4] = '{0, 0, 1, 0};
    localparam int DY_C  [4] = '{0, 0, 0, 1};
    localparam int HP_C  [4] = '{0, 0, 0, 1};
    localparam int VP_C  [4] = '{0, 0, 0, 1};
    localparam logic [7:0] WORD_C [3] = '{8'hA5, 8'h3C, 8'hE4};

    typedef struct packed {
        logic        de;
        logic [7:0]  pix;
        logic        hs;
        logic        vs;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
    } vid_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]  fdata [4];
    logic        fvalid[4];
    logic        uclr  [4];
    logic        rd_w  [4];
    logic [7:0]  pix_w [4];
    logic        de_w  [4];
    logic        hs_w  [4];
    logic        vs_w  [4];
    logic        fs_w  [4];
    logic        uf_w  [4];
    logic [11:0] x_w   [4];
    logic [11:0] y_w   [4];

    int total = 0;
    int bad = 0;
    int tick = 0;
    int ufl_line = -1;

    vga_fetch_timing_if #(.data_width(8)) fif0 ();
    vga_fetch_timing_if #(.data_width(8)) fif1 ();
    vga_fetch_timing_if #(.data_width(8)) fif2 ();
    vga_fetch_timing_if #(.data_width(8)) fif3 ();

    assign fif0.fifo_data = fdata[0]; assign fif0.fifo_valid = fvalid[0]; assign rd_w[0] = fif0.fifo_rd;
    assign fif1.fifo_data = fdata[1]; assign fif1.fifo_valid = fvalid[1]; assign rd_w[1] = fif1.fifo_rd;
    assign fif2.fifo_data = fdata[2]; assign fif2.fifo_valid = fvalid[2]; assign rd_w[2] = fif2.fifo_rd;
    assign fif3.fifo_data = fdata[3]; assign fif3.fifo_valid = fvalid[3]; assign rd_w[3] = fif3.fifo_rd;

    vga_fetch_timing #(
        .h_visible(8), .h_front(2), .h_sync(2), .h_back(2),
        .v_visible(4), .v_front(1), .v_sync(1), .v_back(1),
        .hsync_pol(0), .vsync_pol(0), .bpp(1), .data_width(8), .dbl_x(0), .dbl_y(0)
    ) dut0 (
        .clk(clk), .reset(rst), .fifo(fif0.slave), .underflow_clr(uclr[0]),
        .pixel(pix_w[0]), .de(de_w[0]), .hsync(hs_w[0]), .vsync(vs_w[0]),
        .x(x_w[0]), .y(y_w[0]), .frame_start(fs_w[0]), .underflow(uf_w[0])
    );

    vga_fetch_timing #(
        .h_visible(8), .h_front(2), .h_sync(2), .h_back(2),
        .v_visible(4), .v_front(1), .v_sync(1), .v_back(1),
        .hsync_pol(0), .vsync_pol(0), .bpp(4), .data_width(8), .dbl_x(0), .dbl_y(0)
    ) dut1 (
        .clk(clk), .reset(rst), .fifo(fif1.slave), .underflow_clr(uclr[1]),
        .pixel(pix_w[1]), .de(de_w[1]), .hsync(hs_w[1]), .vsync(vs_w[1]),
        .x(x_w[1]), .y(y_w[1]), .frame_start(fs_w[1]), .underflow(uf_w[1])
    );

    vga_fetch_timing #(
        .h_visible(8), .h_front(2), .h_sync(2), .h_back(2),
        .v_visible(4), .v_front(1), .v_sync(1), .v_back(1),
        .hsync_pol(0), .vsync_pol(0), .bpp(2), .data_width(8), .dbl_x(1), .dbl_y(0)
    ) dut2 (
        .clk(clk), .reset(rst), .fifo(fif2.slave), .underflow_clr(uclr[2]),
        .pixel(pix_w[2]), .de(de_w[2]), .hsync(hs_w[2]), .vsync(vs_w[2]),
        .x(x_w[2]), .y(y_w[2]), .frame_start(fs_w[2]), .underflow(uf_w[2])
    );

    vga_fetch_timing #(
        .h_visible(8), .h_front(2), .h_sync(2), .h_back(2),
        .v_visible(4), .v_front(1), .v_sync(1), .v_back(1),
        .hsync_pol(1), .vsync_pol(1), .bpp(8), .data_width(8), .dbl_x(0), .dbl_y(1)
    ) dut3 (
        .clk(clk), .reset(rst), .fifo(fif3.slave), .underflow_clr(uclr[3]),
        .pixel(pix_w[3]), .de(de_w[3]), .hsync(hs_w[3]), .vsync(vs_w[3]),
        .x(x_w[3]), .y(y_w[3]), .frame_start(fs_w[3]), .underflow(uf_w[3])
    );

    // Clocks since reset release == raster position index (frame is 14 x 7 = 98)
    always @(posedge clk or posedge rst) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    // Show-ahead FIFO for the dbl_y instance: words 10..17 then 20..27 each frame
    initial begin : drv_d
        int n;
        logic pend;
        n = 0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                n = 0;
                pend = 1'b0;
            end else begin
                if (pend) n = n + 1;
                pend = rd_w[3];
            end
            fdata[3] = ((n % 16) < 8) ? 8'(8'h10 + (n % 16)) : 8'(8'h20 + (n % 16) - 8);
        end
    end

    function automatic logic [7:0] word_for(input int id, input int v, input int j);
        if (id == 3) return ((v / 2) == 0) ? 8'(8'h10 + j) : 8'(8'h20 + j);
        if (id == 0 && v == ufl_line) return 8'h00;
        return WORD_C[id];
    endfunction

    function automatic vid_t model_vid(input int id, input int s);
        vid_t m;
        int h, v, p, ppw, slot, j;
        logic vis, hp, vp;
        logic [7:0] w;
        h = s % 14; v = s / 14;
        p = h >> DX_C[id];
        ppw = 8 / BPP_C[id];
        slot = p % ppw; j = p / ppw;
        vis = (h < 8) && (v < 4);
        w = word_for(id, v, j);
        hp = (HP_C[id] != 0); vp = (VP_C[id] != 0);
        m.de  = vis;
        m.pix = vis ? 8'((w >> (slot * BPP_C[id])) & ((1 << BPP_C[id]) - 1)) : 8'h00;
        m.hs  = (h >= 10 && h < 12) ? hp : ~hp;
        m.vs  = (v == 5) ? vp : ~vp;
        m.x   = 12'(h);
        m.y   = 12'(v);
        m.fs  = (s == 97);
        return m;
    endfunction

    function automatic logic model_rd(input int id, input int s, input logic valid);
        int h, v, p, ppw;
        h = s % 14; v = s / 14;
        p = h >> DX_C[id];
        ppw = 8 / BPP_C[id];
        return (h < 8) && (v < 4) && ((p % ppw) == 0) && (DX_C[id] == 0 || (h % 2) == 0)
               && !(DY_C[id] != 0 && (v % 2) == 1) && valid;
    endfunction

    function automatic vid_t get_vid(input int id);
        return {de_w[id], pix_w[id], hs_w[id], vs_w[id], x_w[id], y_w[id], fs_w[id]};
    endfunction

    task automatic test_reset;
        int fs_seen;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (de_w[i] !== 1'b0 || pix_w[i] !== 8'h00 || x_w[i] !== 12'd0 || y_w[i] !== 12'd0 || fs_w[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs dut=%0d got de=%b pix=%h x=%0d y=%0d fs=%b want all zero",
                         i, de_w[i], pix_w[i], x_w[i], y_w[i], fs_w[i]);
            end
            total++;
            if (hs_w[i] !== ~(HP_C[i] != 0) || vs_w[i] !== ~(VP_C[i] != 0)) begin
                bad++;
                $display("FAIL reset_syncs dut=%0d got hs=%b vs=%b want inactive", i, hs_w[i], vs_w[i]);
            end
            total++;
            if (rd_w[i] !== 1'b0 || uf_w[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_rd_uf dut=%0d got rd=%b uf=%b want 0 0", i, rd_w[i], uf_w[i]);
            end
        end
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (de_w[0] !== 1'b1 || x_w[0] !== 12'd0 || y_w[0] !== 12'd0) begin
            bad++;
            $display("FAIL first_pixel got de=%b x=%0d y=%0d want 1 0 0", de_w[0], x_w[0], y_w[0]);
        end
        fs_seen = 0;
        for (int c = 0; c < 96; c++) begin
            @(negedge clk);
            #1;
            if (fs_w[0] === 1'b1) fs_seen++;
        end
        total++;
        if (fs_seen != 0) begin
            bad++;
            $display("FAIL first_frame_start got pulses=%0d want 0", fs_seen);
        end
    endtask

    task automatic test_stream(input int id, input int pops_exp, input string nm);
        vid_t q[$];
        vid_t e, g;
        int pops, s, w;
        logic er;
        pops = 0;
        w = 0;
        while ((tick % 98) != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        total++;
        if ((tick % 98) != 0) begin
            bad++;
            $display("FAIL %s align got pos=%0d want 0", nm, tick % 98);
        end
        for (int c = 0; c < 99; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            s = tick % 98;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = get_vid(id);
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL %s video pos=%0d got=%h want=%h", nm, s, g, e);
                end
            end
            er = model_rd(id, s, fvalid[id]);
            total++;
            if (rd_w[id] !== er) begin
                bad++;
                $display("FAIL %s fifo_rd pos=%0d got=%b want=%b", nm, s, rd_w[id], er);
            end
            if (c < 98 && rd_w[id] === 1'b1) pops++;
            q.push_back(model_vid(id, s));
        end
        total++;
        if (pops != pops_exp) begin
            bad++;
            $display("FAIL %s pops_per_frame got=%0d want=%0d", nm, pops, pops_exp);
        end
    endtask

    task automatic test_underflow;
        vid_t q[$];
        vid_t e, g;
        int s, w;
        logic er;
        ufl_line = 2;
        w = 0;
        while ((tick % 98) != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        total++;
        if ((tick % 98) != 0) begin
            bad++;
            $display("FAIL ufl align got pos=%0d want 0", tick % 98);
        end
        for (int c = 0; c < 99; c++) begin
            if (c > 0) @(negedge clk);
            s = tick % 98;
            fvalid[0] = (s != 28);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                g = get_vid(0);
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL ufl video pos=%0d got=%h want=%h", s, g, e);
                end
            end
            er = model_rd(0, s, fvalid[0]);
            total++;
            if (rd_w[0] !== er) begin
                bad++;
                $display("FAIL ufl fifo_rd pos=%0d got=%b want=%b", s, rd_w[0], er);
            end
            if (s == 28 || s == 29) begin
                total++;
                if (uf_w[0] !== (s == 29)) begin
                    bad++;
                    $display("FAIL ufl flag_set pos=%0d got=%b want=%b", s, uf_w[0], (s == 29));
                end
            end
            q.push_back(model_vid(0, s));
        end
        fvalid[0] = 1'b1;
        ufl_line = -1;
        repeat (98) @(negedge clk);
        #1;
        total++;
        if (uf_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL ufl sticky got=%b want=1", uf_w[0]);
        end
        @(negedge clk);
        uclr[0] = 1'b1;
        @(negedge clk);
        uclr[0] = 1'b0;
        #1;
        total++;
        if (uf_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL ufl clear got=%b want=0", uf_w[0]);
        end
        w = 0;
        while ((tick % 98) != 28 && w < 300) begin
            @(negedge clk);
            w++;
        end
        fvalid[0] = 1'b0;
        uclr[0] = 1'b1;
        #1;
        total++;
        if (rd_w[0] !== 1'b0 || (tick % 98) != 28) begin
            bad++;
            $display("FAIL ufl no_pop got rd=%b pos=%0d want rd=0 pos=28", rd_w[0], tick % 98);
        end
        @(negedge clk);
        fvalid[0] = 1'b1;
        uclr[0] = 1'b0;
        #1;
        total++;
        if (uf_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL ufl set_beats_clear got=%b want=1", uf_w[0]);
        end
        @(negedge clk);
        uclr[0] = 1'b1;
        @(negedge clk);
        uclr[0] = 1'b0;
    endtask

    task automatic test_midframe_reset;
        int w;
        w = 0;
        while ((tick % 98) != 33 && w < 300) begin
            @(negedge clk);
            w++;
        end
        total++;
        if ((tick % 98) != 33 || de_w[0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset precondition got pos=%0d de=%b want 33 1", tick % 98, de_w[0]);
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (de_w[i] !== 1'b0 || pix_w[i] !== 8'h00 || rd_w[i] !== 1'b0 ||
                hs_w[i] !== ~(HP_C[i] != 0) || vs_w[i] !== ~(VP_C[i] != 0)) begin
                bad++;
                $display("FAIL mid_reset dut=%0d got de=%b pix=%h rd=%b hs=%b vs=%b want idle",
                         i, de_w[i], pix_w[i], rd_w[i], hs_w[i], vs_w[i]);
            end
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (de_w[0] !== 1'b1 || x_w[0] !== 12'd0 || y_w[0] !== 12'd0 || fs_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset restart got de=%b x=%0d y=%0d fs=%b want 1 0 0 0",
                     de_w[0], x_w[0], y_w[0], fs_w[0]);
        end
        total++;
        if (pix_w[3] !== 8'h10) begin
            bad++;
            $display("FAIL mid_reset first_word got=%h want=10", pix_w[3]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fvalid[i] = 1'b1;
            uclr[i] = 1'b0;
        end
        fdata[0] = WORD_C[0];
        fdata[1] = WORD_C[1];
        fdata[2] = WORD_C[2];
        fdata[3] = 8'h10;

        test_reset();
        test_stream(0, 4, "bpp1");
        test_stream(1, 16, "bpp4");
        test_stream(2, 4, "bpp2_dblx");
        test_stream(3, 16, "bpp8_dbly");
        test_underflow();
        test_midframe_reset();
        test_stream(3, 16, "dbly_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
